iq_scheduler: RTL

IQ_SCHEDULER -- requirements
Module: iq_scheduler

---
 rtl/iq_scheduler.sv | 122 ++++++++++++
 1 files changed

// File: rtl/iq_scheduler.sv
// Issue-queue scheduler: enqueue slot allocation, writeback wakeup bypass,
// oldest-first issue selection held in a one-deep select register, and occupancy tracking.
module iq_scheduler #(
  parameter int DEPTH  = 8,
  parameter int PREG_W = 6,
  parameter int ROB_W  = 6,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    flush,
  input  logic                    enq_valid,
  output logic                    enq_ready,
  input  logic [PREG_W-1:0]       enq_prs1,
  input  logic [PREG_W-1:0]       enq_prs2,
  input  logic                    enq_src1_busy,
  input  logic                    enq_src2_busy,
  output logic                    enq_src1_state,
  output logic                    enq_src2_state,
  input  logic                    wb_valid,
  input  logic [PREG_W-1:0]       wb_prd,
  input  logic [DEPTH-1:0]        entry_valid,
  input  logic [DEPTH-1:0]        entry_ready,
  input  logic [DEPTH*PREG_W-1:0] entry_prs1,
  input  logic [DEPTH*PREG_W-1:0] entry_prs2,
  input  logic [DEPTH-1:0]        entry_robidx_flag,
  input  logic [DEPTH*ROB_W-1:0]  entry_robidx,
  output logic [DEPTH-1:0]        entry_enq,
  output logic [DEPTH-1:0]        entry_wakeup_src1,
  output logic [DEPTH-1:0]        entry_wakeup_src2,
  output logic [DEPTH-1:0]        entry_issuing,
  output logic                    issue_valid,
  output logic [IDX_W-1:0]        issue_idx,
  input  logic                    issue_ready,
  output logic [OCC_W-1:0]        occupancy
);

  logic [DEPTH-1:0] free_vec;
  logic [DEPTH-1:0] first_free;
  logic [DEPTH-1:0] cand;
  logic             enq_fire;
  logic             issue_fire;
  logic             sel_any;
  logic [IDX_W-1:0] sel_idx;
  logic             best_flag;
  logic [ROB_W-1:0] best_rob;

  // ROB indices carry a wrap flag: with differing flags the larger index is the older one.
  function automatic logic older(input logic fa, input logic [ROB_W-1:0] ia,
                                 input logic fb, input logic [ROB_W-1:0] ib);
    return (fa == fb) ? (ia < ib) : (ia > ib);
  endfunction

  function automatic logic [OCC_W-1:0] occ_next(input logic [OCC_W-1:0] occ,
                                                input logic inc, input logic dec);
    if (inc && !dec) return (occ == OCC_W'(DEPTH)) ? occ : occ + OCC_W'(1);
    if (dec && !inc) return (occ == '0) ? occ : occ - OCC_W'(1);
    return occ;
  endfunction

  // Stage p0: combinational enqueue, wakeup and selection
  assign free_vec       = ~entry_valid;
  assign first_free     = free_vec & (~free_vec + DEPTH'(1));
  assign enq_ready      = ~(&entry_valid) & ~flush;
  assign enq_fire       = enq_valid & enq_ready;
  assign entry_enq      = enq_fire ? first_free : '0;
  assign enq_src1_state = enq_src1_busy & ~(wb_valid & (wb_prd == enq_prs1));
  assign enq_src2_state = enq_src2_busy & ~(wb_valid & (wb_prd == enq_prs2));
  assign issue_fire     = issue_valid & issue_ready & ~flush;

  always_comb begin
    entry_wakeup_src1 = '0;
    entry_wakeup_src2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_wakeup_src1[i] = wb_valid & entry_valid[i] & (entry_prs1[i*PREG_W +: PREG_W] == wb_prd);
      entry_wakeup_src2[i] = wb_valid & entry_valid[i] & (entry_prs2[i*PREG_W +: PREG_W] == wb_prd);
    end
  end

  always_comb begin
    entry_issuing = '0;
    if (issue_fire) entry_issuing[issue_idx] = 1'b1;
  end

  assign cand = entry_ready & ~entry_issuing;

  always_comb begin
    sel_any   = 1'b0;
    sel_idx   = '0;
    best_flag = 1'b0;
    best_rob  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (cand[i] && (!sel_any || older(entry_robidx_flag[i], entry_robidx[i*ROB_W +: ROB_W],
                                        best_flag, best_rob))) begin
        sel_any   = 1'b1;
        sel_idx   = IDX_W'(i);
        best_flag = entry_robidx_flag[i];
        best_rob  = entry_robidx[i*ROB_W +: ROB_W];
      end
    end
  end

  // Stage p1: select register and occupancy counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      issue_valid <= 1'b0;
      issue_idx   <= '0;
      occupancy   <= '0;
    end else if (flush) begin
      issue_valid <= 1'b0;
      occupancy   <= '0;
    end else begin
      if (!issue_valid || issue_fire) begin
        issue_valid <= sel_any;
        issue_idx   <= sel_idx;
      end
      occupancy <= occ_next(occupancy, enq_fire, issue_fire);
    end
  end

endmodule
